afu_scfifo: RTL

- Parametrised single-clock FIFO for AFU datapaths.
- Successor to the single-entry async handshake buffer: configurable width and depth, with selectable normal or show-ahead read mode.
- Adds occupancy count, almost-full/almost-empty thresholds, simultaneous read/write in one cycle, and sticky overflow/underflow error flags.
- Sits between AFU request/response stages where both sides run on the same clock.

---
 rtl/afu_fifo_pkg.sv | 21 ++
 rtl/afu_fifo_ram.sv | 31 +++
 rtl/afu_scfifo.sv | 122 ++++++++++++
 3 files changed

// File: rtl/afu_fifo_pkg.sv
// rtl/afu_fifo_pkg.sv - shared types and elaboration helpers for the AFU FIFOs
package afu_fifo_pkg;

  typedef enum logic {
    FIFO_NORMAL    = 1'b0,
    FIFO_SHOWAHEAD = 1'b1
  } fifo_mode_e;

  // Address width for a given entry count, never below one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/afu_fifo_ram.sv
// rtl/afu_fifo_ram.sv - width x depth register array, sync write, async read
// Ports:
//   clock  write clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address (combinational read)
//   rdata  read data
module afu_fifo_ram #(
  parameter int width = 9,
  parameter int depth = 16,
  parameter int aw    = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Storage is deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/afu_scfifo.sv
// rtl/afu_scfifo.sv - single-clock FIFO with normal or show-ahead read mode
// Ports:
//   clock         single clock, all state on posedge
//   aclr          asynchronous active-high clear
//   data/wrreq    write word and write request
//   rdreq         read request (head acknowledge in show-ahead mode)
//   q             read data
//   empty/full    occupancy at 0 / depth
//   almost_full   usedw >= almost_full_th
//   almost_empty  usedw <= almost_empty_th
//   usedw         occupancy 0..depth
//   overflow      sticky: write requested while full
//   underflow     sticky: read requested while empty
module afu_scfifo
  import afu_fifo_pkg::*;
#(
  parameter int width           = 9,
  parameter int depth           = 16,
  parameter int showahead       = 0,
  parameter int almost_full_th  = 12,
  parameter int almost_empty_th = 2,
  localparam int aw             = clog2_min1(depth)
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic [width-1:0] data,
  input  logic             wrreq,
  input  logic             rdreq,
  output logic [width-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [aw:0]      usedw,
  output logic             overflow,
  output logic             underflow
);

  localparam fifo_mode_e  mode    = (showahead != 0) ? FIFO_SHOWAHEAD : FIFO_NORMAL;
  localparam logic [aw:0] depth_c = (aw+1)'(depth);
  localparam logic [aw:0] af_c    = (aw+1)'(almost_full_th);
  localparam logic [aw:0] ae_c    = (aw+1)'(almost_empty_th);

  if (!is_pow2(depth)) begin : g_bad_depth
    $error("afu_scfifo: depth must be a power of two >= 2");
  end
  if (almost_full_th < 1 || almost_full_th > depth) begin : g_bad_af
    $error("afu_scfifo: almost_full_th out of range 1..depth");
  end
  if (almost_empty_th < 0 || almost_empty_th > depth - 1) begin : g_bad_ae
    $error("afu_scfifo: almost_empty_th out of range 0..depth-1");
  end

  logic [aw-1:0]    wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;
  logic [aw:0]      usedw_nxt;
  logic [width-1:0] ram_q;

  // Acceptance uses only the registered flags, so no request feeds a flag
  // combinationally and a same-cycle write never falls through to q.
  always_comb begin
    wr_acc    = wrreq & ~full;
    rd_acc    = rdreq & ~empty;
    usedw_nxt = usedw;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_nxt = usedw + (aw+1)'(1);
      2'b01:   usedw_nxt = usedw - (aw+1)'(1);
      default: usedw_nxt = usedw;
    endcase
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      usedw        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + aw'(1);
      if (rd_acc) rd_ptr <= rd_ptr + aw'(1);
      usedw        <= usedw_nxt;
      // Flags come from the next occupancy so they move with usedw.
      empty        <= (usedw_nxt == '0);
      full         <= (usedw_nxt == depth_c);
      almost_empty <= (usedw_nxt <= ae_c);
      almost_full  <= (usedw_nxt >= af_c);
      overflow     <= overflow  | (wrreq & full);
      underflow    <= underflow | (rdreq & empty);
    end
  end

  afu_fifo_ram #(
    .width (width),
    .depth (depth),
    .aw    (aw)
  ) u_ram (
    .clock (clock),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (data),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  if (mode == FIFO_SHOWAHEAD) begin : g_showahead
    // Head word is always presented; meaningless (but stable) while empty.
    assign q = ram_q;
  end else begin : g_normal
    logic [width-1:0] q_r;
    always_ff @(posedge clock or posedge aclr) begin
      if (aclr)        q_r <= '0;
      else if (rd_acc) q_r <= ram_q;
    end
    assign q = q_r;
  end

endmodule
